// File: rtl/spi_ram_resp.sv
// spi_ram_resp: single-port SRAM responder for a held-request CPU bus.
// Each accepted request makes at most one SRAM strobe. Single-byte writes
// are replicated to all lanes, and out-of-range addresses raise err_pulse.
module spi_ram_resp #(
    parameter int AW_WORD  = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ram_rd,
    input  logic               ram_wr,
    input  logic [3:0]         ram_rlen4,
    input  logic [3:0]         ram_wlen4,
    input  logic [19:0]        ram_addr,
    input  logic [31:0]        ram_wdata,
    output logic [31:0]        ram_rdata,
    output logic               ram_bus_ready,
    output logic               ram_rdata_ready,
    output logic               sram_cs,
    output logic               sram_we,
    output logic [3:0]         sram_be,
    output logic [AW_WORD-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    output logic               err_pulse
);

    typedef enum logic [2:0] {IDLE, WAIT, WR, RD, RD_DATA} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               wr_op_q, wr_op_d;
    logic               oor_q, oor_d;
    logic [AW_WORD-1:0] addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [19:0]        hi_bits;
    logic               req_oor;
    logic               unused_rlen4;

    // Reads always return the full word, so the read byte enables are not used.
    assign unused_rlen4 = ^ram_rlen4;

    // Any address bit above the SRAM window marks the access out of range.
    assign hi_bits = ram_addr >> (AW_WORD + 2);
    assign req_oor = |hi_bits;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Single-byte writes carry their byte in wdata[7:0], so replicate it to every lane.
    function automatic logic [31:0] steer_wdata(input logic [3:0] be, input logic [31:0] d);
        if (is_one_hot(be)) begin
            return {4{d[7:0]}};
        end
        return d;
    endfunction

    // Next-state, request capture and output decode.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        wr_op_d         = wr_op_q;
        oor_d           = oor_q;
        addr_d          = addr_q;
        be_d            = be_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        ram_bus_ready   = 1'b0;
        ram_rdata_ready = 1'b0;
        sram_cs         = 1'b0;
        sram_we         = 1'b0;
        sram_be         = 4'b0000;
        err_pulse       = 1'b0;
        ram_rdata       = rdata_q;
        sram_addr       = addr_q;
        sram_wdata      = wdata_q;

        case (state_q)
            IDLE: begin
                if (ram_wr || ram_rd) begin
                    // A write wins. The requester keeps ram_rd high, so a read
                    // that loses here is picked up again on the next IDLE cycle.
                    wr_op_d = ram_wr;
                    addr_d  = ram_addr[AW_WORD+1:2];
                    oor_d   = req_oor;
                    be_d    = ram_wlen4;
                    wdata_d = steer_wdata(ram_wlen4, ram_wdata);
                    cnt_d   = 3'd0;
                    if (WAIT_CYC > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = ram_wr ? WR : RD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = wr_op_q ? WR : RD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WR: begin
                ram_bus_ready = 1'b1;
                sram_cs       = !oor_q && (be_q != 4'b0000);
                sram_we       = 1'b1;
                sram_be       = be_q;
                err_pulse     = oor_q;
                state_d       = IDLE;
            end
            RD: begin
                ram_bus_ready = 1'b1;
                sram_cs       = !oor_q;
                err_pulse     = oor_q;
                state_d       = RD_DATA;
            end
            RD_DATA: begin
                ram_rdata_ready = 1'b1;
                rdata_d         = oor_q ? 32'h0 : sram_rdata;
                ram_rdata       = rdata_d;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is held, suppress every strobe so an abandoned access
        // can never produce an accept, a data pulse or an SRAM cycle.
        if (rst) begin
            ram_bus_ready   = 1'b0;
            ram_rdata_ready = 1'b0;
            sram_cs         = 1'b0;
            sram_we         = 1'b0;
            err_pulse       = 1'b0;
        end
    end

    // State, wait counter, captured request and read-data holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            wr_op_q <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_op_q <= wr_op_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_ram_resp.sv
// Directed testbench for spi_ram_resp: a WAIT_CYC=0 instance backed by a
// small SRAM model, and a WAIT_CYC=3 instance for the wait-state timing.
module tb_spi_ram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_mem;

    // WAIT_CYC = 0 instance
    logic        ram_rd, ram_wr;
    logic [3:0]  ram_rlen4, ram_wlen4;
    logic [19:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_bus_ready, ram_rdata_ready;
    logic        sram_cs, sram_we, err_pulse;
    logic [3:0]  sram_be;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    // WAIT_CYC = 3 instance
    logic        w_rd, w_wr;
    logic [3:0]  w_rlen4, w_wlen4;
    logic [19:0] w_addr;
    logic [31:0] w_wdata, w_rdata;
    logic        w_bus_ready, w_rdata_ready;
    logic        w_cs, w_we, w_err;
    logic [3:0]  w_be;
    logic [15:0] w_saddr;
    logic [31:0] w_swdata, w_srdata;

    logic [31:0] mem [0:15];
    int          cs_cnt;
    int          cs_snap;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    spi_ram_resp #(.AW_WORD(16), .WAIT_CYC(0)) u_dut (
        .clk(clk), .rst(rst),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_rlen4(ram_rlen4), .ram_wlen4(ram_wlen4),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_bus_ready(ram_bus_ready), .ram_rdata_ready(ram_rdata_ready),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .err_pulse(err_pulse)
    );

    spi_ram_resp #(.AW_WORD(16), .WAIT_CYC(3)) u_dut_w (
        .clk(clk), .rst(rst),
        .ram_rd(w_rd), .ram_wr(w_wr), .ram_rlen4(w_rlen4), .ram_wlen4(w_wlen4),
        .ram_addr(w_addr), .ram_wdata(w_wdata), .ram_rdata(w_rdata),
        .ram_bus_ready(w_bus_ready), .ram_rdata_ready(w_rdata_ready),
        .sram_cs(w_cs), .sram_we(w_we), .sram_be(w_be), .sram_addr(w_saddr),
        .sram_wdata(w_swdata), .sram_rdata(w_srdata), .err_pulse(w_err)
    );

    // SRAM models: byte-lane writes, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[1]     <= 32'h11223344;
            sram_rdata <= 32'h0;
            w_srdata   <= 32'h0;
            cs_cnt     <= 0;
        end else begin
            if (sram_cs && sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr[3:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
            if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr[3:0]];
            if (sram_cs) cs_cnt <= cs_cnt + 1;
            if (w_cs && !w_we) w_srdata <= 32'hCAFEF00D;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; init_mem = 1'b1;
        ram_rd = 0; ram_wr = 0; ram_rlen4 = 4'hF; ram_wlen4 = 0; ram_addr = 0; ram_wdata = 0;
        w_rd = 0; w_wr = 0; w_rlen4 = 4'hF; w_wlen4 = 0; w_addr = 0; w_wdata = 0;
        step();
        init_mem = 1'b0;
        step();
        // reset state
        chk("rst_bus_ready", ram_bus_ready, 0);
        chk("rst_rdata_ready", ram_rdata_ready, 0);
        chk("rst_cs_we_err", {sram_cs, sram_we, err_pulse}, 0);
        chk("rst_be_addr", {sram_be, sram_addr}, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_rdata", ram_rdata, 0);
        rst = 1'b0;

        // read word 1 at byte address 0x00004
        step();
        ram_rd = 1; ram_addr = 20'h00004;
        chk("rd_T0_ready", ram_bus_ready, 0);
        step();
        chk("rd_T1_ready", ram_bus_ready, 1);
        chk("rd_T1_cs_we", {sram_cs, sram_we}, 2'b10);
        chk("rd_T1_addr", sram_addr, 1);
        chk("rd_T1_rdy", ram_rdata_ready, 0);
        ram_rd = 0;
        step();
        chk("rd_T2_rdy", ram_rdata_ready, 1);
        chk("rd_T2_data", ram_rdata, 32'h11223344);
        chk("rd_T2_ready", ram_bus_ready, 0);
        step();
        chk("rd_T3_rdy", ram_rdata_ready, 0);
        chk("rd_T3_hold", ram_rdata, 32'h11223344);

        // single-byte write, lane 2
        ram_wr = 1; ram_addr = 20'h00006; ram_wlen4 = 4'b0100; ram_wdata = 32'h000000A5;
        step();
        chk("wb_ready", ram_bus_ready, 1);
        chk("wb_cs_we", {sram_cs, sram_we}, 2'b11);
        chk("wb_addr", sram_addr, 1);
        chk("wb_be", sram_be, 4'b0100);
        chk("wb_wdata", sram_wdata, 32'hA5A5A5A5);
        ram_wr = 0;
        step();
        chk("wb_idle_ready", ram_bus_ready, 0);
        chk("wb_idle_cs_we", {sram_cs, sram_we}, 0);

        // two-byte write is not replicated
        ram_wr = 1; ram_addr = 20'h00008; ram_wlen4 = 4'b0011; ram_wdata = 32'hDEADBEEF;
        step();
        chk("wh_be", sram_be, 4'b0011);
        chk("wh_wdata", sram_wdata, 32'hDEADBEEF);
        chk("wh_addr", sram_addr, 2);
        ram_wr = 0;
        step();

        // read with low address bits set returns the aligned word
        ram_rd = 1; ram_addr = 20'h00007;
        step();
        chk("ra_addr", sram_addr, 1);
        ram_rd = 0;
        step();
        chk("ra_data", ram_rdata, 32'h11A53344);
        step();

        // write with no byte enables: accepted, no SRAM access
        cs_snap = cs_cnt;
        ram_wr = 1; ram_addr = 20'h00004; ram_wlen4 = 4'b0000; ram_wdata = 32'hFFFFFFFF;
        step();
        chk("wz_ready", ram_bus_ready, 1);
        chk("wz_cs", sram_cs, 0);
        ram_wr = 0;
        step();
        chk("wz_no_strobe", cs_cnt - cs_snap, 0);

        // out-of-range read
        ram_rd = 1; ram_addr = 20'h40000;
        step();
        chk("oor_ready", ram_bus_ready, 1);
        chk("oor_err", err_pulse, 1);
        chk("oor_cs", sram_cs, 0);
        ram_rd = 0;
        step();
        chk("oor_rdy", ram_rdata_ready, 1);
        chk("oor_data", ram_rdata, 32'h0);
        chk("oor_err_clr", err_pulse, 0);
        step();

        // read and write together: write first, one IDLE cycle, then read
        cs_snap = cs_cnt;
        ram_wr = 1; ram_rd = 1; ram_addr = 20'h0000C; ram_wlen4 = 4'b1111; ram_wdata = 32'h0BADF00D;
        step();
        chk("rw_w_ready", ram_bus_ready, 1);
        chk("rw_w_we", sram_we, 1);
        ram_wr = 0;
        step();
        chk("rw_idle_ready", ram_bus_ready, 0);
        chk("rw_idle_cs", sram_cs, 0);
        step();
        chk("rw_r_ready", ram_bus_ready, 1);
        chk("rw_r_cs_we", {sram_cs, sram_we}, 2'b10);
        ram_rd = 0;
        step();
        chk("rw_r_rdy", ram_rdata_ready, 1);
        chk("rw_r_data", ram_rdata, 32'h0BADF00D);
        step();
        chk("rw_strobes", cs_cnt - cs_snap, 2);

        // reset during RD_DATA, then a request held across reset release
        ram_rd = 1; ram_addr = 20'h00004;
        step();
        chk("rr_T1_ready", ram_bus_ready, 1);
        step();
        rst = 1'b1;
        #1;
        chk("rr_no_rdy", ram_rdata_ready, 0);
        step();
        chk("rr_after_ready", {ram_bus_ready, ram_rdata_ready}, 0);
        chk("rr_after_sram", {sram_cs, sram_we, err_pulse, sram_be}, 0);
        chk("rr_after_rdata", ram_rdata, 0);
        rst = 1'b0;
        #1;
        chk("rr_idle_ready", ram_bus_ready, 0);
        step();
        chk("rr_new_ready", ram_bus_ready, 1);
        chk("rr_new_addr", sram_addr, 1);
        ram_rd = 0;
        step();
        chk("rr_new_rdy", ram_rdata_ready, 1);
        chk("rr_new_data", ram_rdata, 32'h11A53344);
        step();

        // WAIT_CYC = 3 instance: accept at T+4, data at T+5
        w_rd = 1; w_addr = 20'h00010;
        step();
        chk("w_T1_ready", w_bus_ready, 0);
        step();
        chk("w_T2_ready", w_bus_ready, 0);
        step();
        chk("w_T3_ready", {w_bus_ready, w_cs}, 0);
        step();
        chk("w_T4_ready", w_bus_ready, 1);
        chk("w_T4_cs_addr", {w_cs, w_saddr}, {1'b1, 16'd4});
        w_rd = 0;
        step();
        chk("w_T5_rdy", w_rdata_ready, 1);
        chk("w_T5_data", w_rdata, 32'hCAFEF00D);
        step();
        chk("w_T6_rdy", {w_rdata_ready, w_bus_ready}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_resp.md
SPI_RAM_RESP -- requirements
Module: spi_ram_resp

Interface
REQ-001 The block SHALL be parameterised as follows, one per line (name, default, meaning):
- AW_WORD, 16, SRAM word-address width; capacity 2^AW_WORD 32-bit words.
- WAIT_CYC, 0, extra wait cycles (0-7) inserted before each access is accepted.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- ram_rd, in, 1, read request; held until accepted.
- ram_wr, in, 1, write request; held until accepted.
- ram_rlen4, in, 4, read byte enables (ignored; full word always returned).
- ram_wlen4, in, 4, write byte enables.
- ram_addr, in, 20, byte address.
- ram_wdata, in, 32, write data.
- ram_rdata, out, 32, read data.
- ram_bus_ready, out, 1, request-accept pulse.
- ram_rdata_ready, out, 1, read-data-valid pulse.
- sram_cs, out, 1, SRAM chip select.
- sram_we, out, 1, SRAM write enable.
- sram_be, out, 4, SRAM byte enables.
- sram_addr, out, AW_WORD, SRAM word address.
- sram_wdata, out, 32, SRAM write data.
- sram_rdata, in, 32, SRAM read data, valid 1 cycle after a read strobe.
- err_pulse, out, 1, out-of-range access flag.

REQ-003 The design SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT, WR, RD, RD_DATA.
REQ-005 IDLE SHALL go to WAIT on ram_rd|ram_wr when WAIT_CYC>0, otherwise directly to WR (if ram_wr) or RD (if ram_rd only).
REQ-006 WAIT SHALL count WAIT_CYC cycles, then go to WR or RD based on the request sampled on IDLE exit.
REQ-007 If ram_wr and ram_rd are both high at IDLE exit, write SHALL win; the read stays pending and is served afterwards.
REQ-008 WR SHALL last 1 cycle with ram_bus_ready=1, sram_cs=1, sram_we=1, then return to IDLE.
REQ-009 RD SHALL last 1 cycle with ram_bus_ready=1, sram_cs=1, sram_we=0, then go to RD_DATA.
REQ-010 RD_DATA SHALL last 1 cycle with ram_rdata_ready=1 and ram_rdata=sram_rdata (registered copy held until the next read), then return to IDLE.
REQ-011 Latency with WAIT_CYC=0: write accept 1 cycle after request; read data 2 cycles after request.
REQ-012 sram_addr SHALL equal ram_addr[AW_WORD+1:2], captured on IDLE exit and held for the whole access.
REQ-013 Byte steering when ram_wlen4 is one-hot: ram_wdata[7:0] SHALL be replicated to all four lanes and sram_be=ram_wlen4.
REQ-014 For any other nonzero ram_wlen4: sram_wdata=ram_wdata and sram_be=ram_wlen4.
REQ-015 A write with ram_wlen4=0 SHALL be accepted with sram_cs=0 (no SRAM access).
REQ-016 Out of range (ram_addr[19:AW_WORD+2]!=0), the access SHALL be accepted normally with sram_cs=0 and err_pulse=1 for the accept cycle; a read returns 32'h0.
REQ-017 ram_addr[1:0] SHALL be ignored for reads; the word is returned aligned.
REQ-018 sram_cs and sram_we SHALL never be high outside WR/RD; at most one SRAM access SHALL occur per accepted request.
REQ-019 ram_bus_ready and ram_rdata_ready SHALL be single-cycle pulses; back-to-back requests SHALL pass through IDLE for 1 cycle between accesses.

Reset
REQ-020 On rst=1 at a clk edge: FSM->IDLE, wait counter=0, and all outputs 0 (including ram_rdata); any in-flight access is abandoned with no accept or data pulse.
REQ-021 A request held across reset release SHALL be served as new, starting from IDLE in the cycle after rst falls.

Verification
REQ-022 WAIT_CYC=0, write ram_addr=0x00006, wlen4=4'b0100, wdata=0x000000A5 -> next cycle ram_bus_ready=1, sram_addr=1, sram_be=4'b0100, sram_wdata=0xA5A5A5A5.
REQ-023 Read ram_addr=0x00004 with SRAM word1=0x11223344 -> ram_bus_ready at T+1, ram_rdata_ready at T+2, ram_rdata=0x11223344.
REQ-024 WAIT_CYC=3, read -> ram_bus_ready at T+4, ram_rdata_ready at T+5.
REQ-025 ram_rd and ram_wr high together -> write accepted first, IDLE for 1 cycle, then read accepted; exactly two SRAM strobes.
REQ-026 AW_WORD=16, read ram_addr=0x40000 -> err_pulse=1, sram_cs=0, ram_rdata=0 on ram_rdata_ready.
REQ-027 rst asserted in RD_DATA -> no ram_rdata_ready pulse, all outputs 0 the next cycle, FSM in IDLE.
